// File: rtl/i3c_ahb_manager.sv
// Single-outstanding AHB-Lite manager: converts a valid/ready CSR request into
// one non-pipelined AHB transfer and returns data/error/wait info on a response channel.
module i3c_ahb_manager #(
  parameter int AhbAddrWidth = 32,
  parameter int AhbDataWidth = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [AhbAddrWidth-1:0]   req_addr_i,
  input  logic [2:0]                req_size_i,
  input  logic [AhbDataWidth-1:0]   req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [AhbDataWidth-1:0]   rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [7:0]                rsp_wait_o,
  output logic [AhbAddrWidth-1:0]   haddr_o,
  output logic [2:0]                hburst_o,
  output logic [3:0]                hprot_o,
  output logic [2:0]                hsize_o,
  output logic [1:0]                htrans_o,
  output logic [AhbDataWidth-1:0]   hwdata_o,
  output logic [AhbDataWidth/8-1:0] hwstrb_o,
  output logic                      hwrite_o,
  output logic                      hsel_o,
  output logic                      hready_o,
  input  logic [AhbDataWidth-1:0]   hrdata_i,
  input  logic                      hreadyout_i,
  input  logic                      hresp_i
);

  localparam int NumBytes = AhbDataWidth / 8;
  localparam int SizeMax  = $clog2(NumBytes);

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic                    r_req_ready;
  logic                    r_rsp_valid;
  logic                    r_rsp_err;
  logic [AhbDataWidth-1:0] r_rsp_rdata;
  logic [7:0]              r_wait;
  logic                    r_err_flag;
  logic [AhbAddrWidth-1:0] r_haddr;
  logic [2:0]              r_hsize;
  logic [1:0]              r_htrans;
  logic                    r_hwrite;
  logic                    r_hsel;
  logic [AhbDataWidth-1:0] r_hwdata;
  logic [NumBytes-1:0]     r_hwstrb;
  logic [AhbDataWidth-1:0] r_wdata;

  logic w_accept;
  logic w_legal;
  logic w_err_final;

  // Size must fit the bus and the address must be naturally aligned to it.
  function automatic logic f_legal(input logic [AhbAddrWidth-1:0] addr,
                                   input logic [2:0] size);
    logic ok;
    ok = (int'(size) <= SizeMax);
    for (int i = 0; i < SizeMax; i++) begin
      if ((i < int'(size)) && addr[i]) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [NumBytes-1:0] f_strb(input logic [AhbAddrWidth-1:0] addr,
                                                 input logic [2:0] size);
    logic [NumBytes-1:0] strb;
    int off;
    int len;
    strb = '0;
    off  = int'(addr[SizeMax-1:0]);
    len  = 1 << size;
    for (int i = 0; i < NumBytes; i++) begin
      strb[i] = (i >= off) && (i < off + len);
    end
    return strb;
  endfunction

  assign w_accept    = req_valid_i & r_req_ready;
  assign w_legal     = f_legal(req_addr_i, req_size_i);
  assign w_err_final = r_err_flag | hresp_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept)    w_state_next = w_legal ? ST_ADDR : ST_RESP;
      ST_ADDR: if (hreadyout_i) w_state_next = ST_DATA;
      ST_DATA: if (hreadyout_i) w_state_next = ST_RESP;
      ST_RESP: if (rsp_ready_i) w_state_next = ST_IDLE;
      default:                  w_state_next = ST_IDLE;
    endcase
  end

  // Output registers are loaded on the transition into the phase they describe,
  // so every bus and response output comes straight from a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_wait      <= '0;
      r_err_flag  <= 1'b0;
      r_haddr     <= '0;
      r_hsize     <= '0;
      r_htrans    <= HtransIdle;
      r_hwrite    <= 1'b0;
      r_hsel      <= 1'b0;
      r_hwdata    <= '0;
      r_hwstrb    <= '0;
      r_wdata     <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            if (w_legal) begin
              r_htrans <= HtransNonseq;
              r_hsel   <= 1'b1;
              r_haddr  <= req_addr_i;
              r_hsize  <= req_size_i;
              r_hwrite <= req_write_i;
              r_wdata  <= req_wdata_i;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end
          end
        end
        ST_ADDR: begin
          if (hreadyout_i) begin
            r_htrans <= HtransIdle;
            r_hsel   <= 1'b0;
            r_hwdata <= r_hwrite ? r_wdata : '0;
            r_hwstrb <= r_hwrite ? f_strb(r_haddr, r_hsize) : '0;
          end
        end
        ST_DATA: begin
          if (!hreadyout_i) begin
            if (r_wait != 8'hFF) r_wait <= r_wait + 8'd1;
            if (hresp_i) r_err_flag <= 1'b1;
          end else begin
            r_hwdata    <= '0;
            r_hwstrb    <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err_final;
            r_rsp_rdata <= (!r_hwrite && !w_err_final) ? hrdata_i : '0;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_wait      <= '0;
            r_err_flag  <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_wait_o  = r_wait;
  assign haddr_o     = r_haddr;
  assign hburst_o    = 3'b000;
  assign hprot_o     = 4'b0011;
  assign hsize_o     = r_hsize;
  assign htrans_o    = r_htrans;
  assign hwdata_o    = r_hwdata;
  assign hwstrb_o    = r_hwstrb;
  assign hwrite_o    = r_hwrite;
  assign hsel_o      = r_hsel;
  assign hready_o    = hreadyout_i;

endmodule

// File: tb/tb_i3c_ahb_manager.sv
// Bench for i3c_ahb_manager: directed vector table, reset-in-flight sequence and
// random transfers scored against a transaction-level model.
module tb_i3c_ahb_manager;

  localparam int AW = 32;
  localparam int DW = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_write_i;
  logic [AW-1:0] req_addr_i;
  logic [2:0]    req_size_i;
  logic [DW-1:0] req_wdata_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic [7:0]    rsp_wait_o;
  logic [AW-1:0] haddr_o;
  logic [2:0]    hburst_o;
  logic [3:0]    hprot_o;
  logic [2:0]    hsize_o;
  logic [1:0]    htrans_o;
  logic [DW-1:0] hwdata_o;
  logic [7:0]    hwstrb_o;
  logic          hwrite_o;
  logic          hsel_o;
  logic          hready_o;
  logic [DW-1:0] hrdata_i;
  logic          hreadyout_i;
  logic          hresp_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  i3c_ahb_manager #(.AhbAddrWidth(AW), .AhbDataWidth(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_wait_o(rsp_wait_o),
    .haddr_o(haddr_o), .hburst_o(hburst_o), .hprot_o(hprot_o), .hsize_o(hsize_o),
    .htrans_o(htrans_o), .hwdata_o(hwdata_o), .hwstrb_o(hwstrb_o), .hwrite_o(hwrite_o),
    .hsel_o(hsel_o), .hready_o(hready_o),
    .hrdata_i(hrdata_i), .hreadyout_i(hreadyout_i), .hresp_i(hresp_i)
  );

  // errMode: 0 none, 1 two-cycle error, 2 hresp only on the final cycle,
  // 3 hresp on the first wait cycle only (error remembered by the manager).
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    int          aw;
    int          dw;
    int          errMode;
    logic [63:0] hrVal;
    int          hold;
    int          expLat;
    logic        expErr;
    logic [63:0] expRdata;
    int          expWait;
    logic [7:0]  expStrb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(logic write, logic [31:0] addr, logic [2:0] size,
                                 logic [63:0] wdata, int aw, int dw, int errMode,
                                 logic [63:0] hrVal, int hold, int expLat, logic expErr,
                                 logic [63:0] expRdata, int expWait, logic [7:0] expStrb);
    vec_t v;
    v.write = write; v.addr = addr; v.size = size; v.wdata = wdata;
    v.aw = aw; v.dw = dw; v.errMode = errMode; v.hrVal = hrVal; v.hold = hold;
    v.expLat = expLat; v.expErr = expErr; v.expRdata = expRdata;
    v.expWait = expWait; v.expStrb = expStrb;
    return v;
  endfunction

  // Transaction-level reference: what the response must look like, from the rules alone.
  function automatic vec_t modelVec(vec_t v);
    vec_t r;
    int bytes;
    int mask;
    logic legal;
    r = v;
    legal = 1'b0;
    bytes = 1;
    if (int'(v.size) <= 3) begin
      bytes = 1 << int'(v.size);
      legal = (int'(v.addr % 32'(bytes)) == 0);
    end
    if (!legal) begin
      r.expLat = 1; r.expErr = 1'b1; r.expRdata = '0; r.expWait = 0; r.expStrb = '0;
    end else begin
      r.expLat   = 3 + v.aw + v.dw;
      r.expErr   = (v.errMode != 0);
      r.expWait  = (v.dw > 255) ? 255 : v.dw;
      r.expRdata = (!v.write && !r.expErr) ? v.hrVal : 64'd0;
      mask       = (1 << bytes) - 1;
      r.expStrb  = v.write ? 8'(mask << int'(v.addr % 32'd8)) : 8'd0;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".req_ready"}, req_ready_o, 1);
    checkOutput({tag, ".rsp_valid"}, rsp_valid_o, 0);
    checkOutput({tag, ".rsp_rdata"}, rsp_rdata_o, 0);
    checkOutput({tag, ".rsp_err"},   rsp_err_o, 0);
    checkOutput({tag, ".rsp_wait"},  rsp_wait_o, 0);
    checkOutput({tag, ".haddr"},     haddr_o, 0);
    checkOutput({tag, ".hburst"},    hburst_o, 0);
    checkOutput({tag, ".hprot"},     hprot_o, 4'b0011);
    checkOutput({tag, ".hsize"},     hsize_o, 0);
    checkOutput({tag, ".htrans"},    htrans_o, 0);
    checkOutput({tag, ".hwdata"},    hwdata_o, 0);
    checkOutput({tag, ".hwstrb"},    hwstrb_o, 0);
    checkOutput({tag, ".hwrite"},    hwrite_o, 0);
    checkOutput({tag, ".hsel"},      hsel_o, 0);
    checkOutput({tag, ".hready"},    hready_o, hreadyout_i);
  endtask

  // Drives one request, plays the subordinate for it, then applies response backpressure.
  task automatic applyStimulus(input vec_t v, input string tag);
    int   aw, dw, phase, nonseq, lat;
    logic seenData, seenAddr, legal;
    logic [7:0]  seenStrb;
    logic [63:0] seenWdata;
    logic [31:0] seenHaddr;
    logic [2:0]  seenHsize;
    logic        seenHwrite;
    aw = v.aw; dw = v.dw; phase = 0; nonseq = 0; lat = 0;
    seenData = 0; seenAddr = 0; seenStrb = '0; seenWdata = '0;
    seenHaddr = '0; seenHsize = '0; seenHwrite = 0;
    legal = (v.expLat != 1);

    @(negedge clk_i);
    checkOutput({tag, ".req_ready_idle"}, req_ready_o, 1);
    req_valid_i = 1'b1; req_write_i = v.write; req_addr_i = v.addr;
    req_size_i = v.size; req_wdata_i = v.wdata;
    hreadyout_i = 1'b1; hresp_i = 1'b0; hrdata_i = {$urandom, $urandom};

    for (int n = 1; n <= 60; n++) begin
      @(negedge clk_i);
      req_valid_i = 1'b0;
      if (rsp_valid_o) begin
        lat = n;
        break;
      end
      if (htrans_o == 2'b10) begin
        nonseq++;
        if (!seenAddr) begin
          seenAddr = 1; seenHaddr = haddr_o; seenHsize = hsize_o; seenHwrite = hwrite_o;
        end
        if (aw > 0) begin
          hreadyout_i = 1'b0; hresp_i = 1'($urandom_range(0, 1)); aw--;
        end else begin
          hreadyout_i = 1'b1; hresp_i = 1'b0; phase = 1;
        end
      end else if (phase == 1) begin
        if (!seenData) begin
          seenData = 1; seenStrb = hwstrb_o; seenWdata = hwdata_o;
        end
        if (dw > 0) begin
          hreadyout_i = 1'b0;
          hresp_i = ((v.errMode == 1) && (dw == 1)) || ((v.errMode == 3) && (dw == v.dw));
          hrdata_i = {$urandom, $urandom};
          dw--;
        end else begin
          hreadyout_i = 1'b1;
          hresp_i = (v.errMode == 1) || (v.errMode == 2);
          hrdata_i = v.hrVal;
          phase = 2;
        end
      end else begin
        hreadyout_i = 1'b1; hresp_i = 1'b0;
      end
    end

    checkOutput({tag, ".latency"}, lat, v.expLat);
    if (lat == 0) return;
    checkOutput({tag, ".rsp_err"},   rsp_err_o, v.expErr);
    checkOutput({tag, ".rsp_rdata"}, rsp_rdata_o, v.expRdata);
    checkOutput({tag, ".rsp_wait"},  rsp_wait_o, v.expWait);
    checkOutput({tag, ".nonseq"},    nonseq, legal ? 1 + v.aw : 0);
    checkOutput({tag, ".hwstrb"},    seenStrb, v.expStrb);
    checkOutput({tag, ".hwdata"},    seenWdata, (legal && v.write) ? v.wdata : 64'd0);
    checkOutput({tag, ".htrans_resp"}, htrans_o, 0);
    if (legal) begin
      checkOutput({tag, ".haddr"},  seenHaddr, v.addr);
      checkOutput({tag, ".hsize"},  seenHsize, v.size);
      checkOutput({tag, ".hwrite"}, seenHwrite, v.write);
    end

    for (int h = 0; h < v.hold; h++) begin
      rsp_ready_i = 1'b0;
      req_valid_i = 1'b1;
      hreadyout_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      checkOutput({tag, ".hold_valid"},  rsp_valid_o, 1);
      checkOutput({tag, ".hold_err"},    rsp_err_o, v.expErr);
      checkOutput({tag, ".hold_rdata"},  rsp_rdata_o, v.expRdata);
      checkOutput({tag, ".hold_wait"},   rsp_wait_o, v.expWait);
      checkOutput({tag, ".hold_ready"},  req_ready_o, 0);
      checkOutput({tag, ".hold_htrans"}, htrans_o, 0);
      checkOutput({tag, ".hold_hready"}, hready_o, hreadyout_i);
    end

    req_valid_i = 1'b0; rsp_ready_i = 1'b1; hreadyout_i = 1'b1; hresp_i = 1'b0;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    checkOutput({tag, ".post_ready"}, req_ready_o, 1);
    checkOutput({tag, ".post_valid"}, rsp_valid_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    rst_ni = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0;
    req_size_i = '0; req_wdata_i = '0; rsp_ready_i = 1'b0;
    hrdata_i = '0; hreadyout_i = 1'b1; hresp_i = 1'b0;

    //                 wr  addr       sz wdata                    aw dw em hrVal                    hold lat err rdata                    wait strb
    vecs.push_back(mkVec(1, 32'h100, 2, 64'hDEADBEEF,             0, 0, 0, 64'h0,                   0,   3,  0,  64'h0,                   0,   8'h0F));
    vecs.push_back(mkVec(0, 32'h104, 2, 64'h0,                    0, 3, 0, 64'h12345678_00000000,   0,   6,  0,  64'h12345678_00000000,   3,   8'h00));
    vecs.push_back(mkVec(0, 32'h108, 3, 64'h0,                    0, 1, 1, 64'hCAFE,                0,   4,  1,  64'h0,                   1,   8'h00));
    vecs.push_back(mkVec(1, 32'h102, 2, 64'h5A5A,                 0, 0, 0, 64'h0,                   0,   1,  1,  64'h0,                   0,   8'h00));
    vecs.push_back(mkVec(0, 32'h100, 4, 64'h0,                    0, 0, 0, 64'h77,                  0,   1,  1,  64'h0,                   0,   8'h00));
    vecs.push_back(mkVec(1, 32'h107, 0, 64'hAB000000_00000000,    2, 0, 0, 64'h0,                   0,   5,  0,  64'h0,                   0,   8'h80));
    vecs.push_back(mkVec(1, 32'h10A, 1, 64'h0000_BEEF_0000_0000,  0, 0, 2, 64'h0,                   0,   3,  1,  64'h0,                   0,   8'h0C));
    vecs.push_back(mkVec(0, 32'h010, 3, 64'h0,                    1, 2, 3, 64'h55,                  0,   6,  1,  64'h0,                   2,   8'h00));
    vecs.push_back(mkVec(0, 32'h020, 3, 64'h0,                    0, 0, 0, 64'h01234567_89ABCDEF,   10,  3,  0,  64'h01234567_89ABCDEF,   0,   8'h00));
    vecs.push_back(mkVec(1, 32'h000, 3, 64'h11223344_55667788,    0, 0, 0, 64'h0,                   0,   3,  0,  64'h0,                   0,   8'hFF));
    vecs.push_back(mkVec(1, 32'h106, 1, 64'hCDEF0000_00000000,    0, 1, 0, 64'h0,                   0,   4,  0,  64'h0,                   1,   8'hC0));
    vecs.push_back(mkVec(0, 32'h101, 1, 64'h0,                    0, 0, 0, 64'h0,                   3,   1,  1,  64'h0,                   0,   8'h00));

    repeat (2) @(negedge clk_i);
    checkResetValues("reset");
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while the data phase is stretched by wait states.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h40; req_size_i = 3'd3;
    hreadyout_i = 1'b1; hresp_i = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    checkOutput("rstseq.nonseq", htrans_o, 2'b10);
    hreadyout_i = 1'b1;
    @(negedge clk_i);
    hreadyout_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rstseq.wait1", rsp_wait_o, 1);
    @(negedge clk_i);
    checkOutput("rstseq.wait2", rsp_wait_o, 2);
    rst_ni = 1'b0;
    #1;
    checkResetValues("rstmid");
    for (int k = 0; k < 3; k++) begin
      hreadyout_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      checkOutput("rstlow.rsp_valid", rsp_valid_o, 0);
      checkOutput("rstlow.req_ready", req_ready_o, 1);
      checkOutput("rstlow.htrans", htrans_o, 0);
      checkOutput("rstlow.hready", hready_o, hreadyout_i);
    end
    rst_ni = 1'b1; hreadyout_i = 1'b1;
    applyStimulus(mkVec(0, 32'h48, 3, 64'h0, 0, 1, 0, 64'hFEEDFACE_0BADF00D, 0,
                        4, 0, 64'hFEEDFACE_0BADF00D, 1, 8'h00), "afterrst");

    for (int r = 0; r < 40; r++) begin
      int sz;
      v.write = 1'($urandom_range(0, 1));
      sz = $urandom_range(0, 9);
      v.size = (sz < 9) ? 3'(sz % 4) : 3'($urandom_range(4, 7));
      v.addr = 32'($urandom_range(0, 255));
      if (($urandom_range(0, 3) != 0) && (v.size <= 3)) v.addr = v.addr & ~((32'd1 << v.size) - 1);
      v.wdata = {$urandom, $urandom};
      v.hrVal = {$urandom, $urandom};
      v.aw = $urandom_range(0, 2);
      v.dw = $urandom_range(0, 4);
      v.errMode = $urandom_range(0, 3);
      if ((v.dw == 0) && ((v.errMode == 1) || (v.errMode == 3))) v.errMode = 2;
      v.hold = $urandom_range(0, 3);
      v = modelVec(v);
      applyStimulus(v, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i3c_ahb_manager.md
# i3c_ahb_manager

AHB-Lite manager that turns a simple valid/ready CSR request stream into single, non-pipelined AHB-Lite transfers toward the I3C core's AHB subordinate port, and returns read data and error status on a response channel. It sits at the initiator end of the same AHB-Lite bus the I3C core terminates. It serves as the bus driver for integration benches, firmware-less bring-up and any subsystem that must program the I3C CSRs without a CPU. Exactly one transfer is outstanding at a time.

## Interface
Parameters:
- AhbAddrWidth, 32, width of haddr_o and req_addr_i
- AhbDataWidth, 64, data bus width (32 or 64)

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset; one clock; asynchronous and active-low
- req_valid_i  input  1  request valid
- req_ready_o  output  1  request accepted when high with req_valid_i
- req_write_i  input  1  1 = write, 0 = read
- req_addr_i  input  AhbAddrWidth  byte address
- req_size_i  input  3  AHB hsize encoding (0 = byte … 3 = dword)
- req_wdata_i  input  AhbDataWidth  write data, already lane-placed by requester
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  response consumed
- rsp_rdata_o  output  AhbDataWidth  captured hrdata_i (zero for writes and errors)
- rsp_err_o  output  1  transfer ended with error or was rejected
- rsp_wait_o  output  8  data-phase wait states seen, saturating at 255
- haddr_o  output  AhbAddrWidth
- hburst_o  output  3  fixed 3'b000 (SINGLE)
- hprot_o  output  4  fixed 4'b0011
- hsize_o  output  3
- htrans_o  output  2  IDLE 2'b00 / NONSEQ 2'b10 only
- hwdata_o  output  AhbDataWidth
- hwstrb_o  output  AhbDataWidth/8
- hwrite_o  output  1
- hsel_o  output  1
- hready_o  output  1  equals hreadyout_i, combinational (single-subordinate loopback)
- hrdata_i  input  AhbDataWidth
- hreadyout_i  input  1
- hresp_i  input  1

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: req_ready_o=1. On req_valid_i && req_ready_o, latch all request fields and check legality.
  - Illegal request: req_size_i > log2(AhbDataWidth/8), or req_addr_i not aligned to 2^req_size_i. The request goes to RESP with rsp_err_o=1 and no bus activity.
  - Legal request: go to ADDR.
- ADDR: htrans_o=NONSEQ, hsel_o=1; haddr_o, hsize_o and hwrite_o come from the latched fields. Stay in ADDR while hreadyout_i=0. Go to DATA on hreadyout_i=1.
- DATA: htrans_o=IDLE, hsel_o=0. For writes, hwdata_o holds the latched wdata.
  - hwstrb_o = ((1<<2^size)-1) << addr[log2(AhbDataWidth/8)-1:0]; all zero for reads.
  - Each cycle with hreadyout_i=0 increments the wait counter.
  - hreadyout_i=0 with hresp_i=1 is the first error cycle: set an error flag and keep waiting.
  - On hreadyout_i=1, complete the transfer:
    - err = flag | hresp_i.
    - Read without error: rsp_rdata_o = hrdata_i; otherwise rsp_rdata_o = 0.
    - Go to RESP.
- RESP: rsp_valid_o=1 and rsp_* are stable until rsp_ready_i. On rsp_ready_i, go to IDLE and clear the wait counter and error flag. A new request is not accepted in the same cycle.
- AHB outputs outside ADDR: htrans_o=0, hsel_o=0. haddr_o, hsize_o and hwrite_o hold their last values.
- hwdata_o and hwstrb_o are zero outside DATA.

## Timing
- Reset values: state IDLE, req_ready_o=1. All other outputs are 0 except hprot_o=4'b0011 and hready_o, which follows hreadyout_i.
- Zero-wait transfer, with accept at edge 0:
  - ADDR is visible in cycle 1.
  - DATA is visible in cycle 2, completing at edge 3.
  - rsp_valid_o is high in cycle 3.
  - Accept to response is 3 cycles; add 1 cycle per wait state in either phase.
- Rejected request: rsp_valid_o is high in cycle 1, with no htrans_o activity.
- All outputs are registered except hready_o.
- Reset asserted mid-transfer: state returns to IDLE immediately (asynchronously), all outputs go to reset values and the pending response is dropped.
- hresp_i in ADDR is ignored. hresp_i with hreadyout_i=1 in DATA without a preceding first-error cycle is still reported as an error.
- Backpressure: while rsp_ready_i=0, RESP holds indefinitely and req_ready_o stays 0.

## Test plan
- Write, zero wait states:
  - Stimulus: addr 0x100, size 2, data 0xDEADBEEF (low lane), AhbDataWidth=64.
  - Required: NONSEQ in cycle 1, hwstrb_o=0x0F in cycle 2, rsp_valid_o in cycle 3 with rsp_err_o=0 and rsp_wait_o=0.
- Read at addr 0x104, size 2, 3 data-phase wait states, hrdata_i=0x12345678_00000000:
  - rsp_rdata_o=0x12345678_00000000, rsp_wait_o=3, rsp_valid_o 6 cycles after accept.
- Two-cycle error response (hreadyout 0/hresp 1, then hreadyout 1/hresp 1):
  - rsp_err_o=1, rsp_rdata_o=0.
- Misaligned request (addr 0x102, size 2) and oversize request (size 4):
  - Each yields rsp_err_o=1 one cycle after accept, with htrans_o never leaving IDLE.
- rsp_ready_i held low for 10 cycles:
  - rsp_* stable throughout, req_ready_o=0, no second NONSEQ.
  - Exactly one cycle after the handshake, req_ready_o=1.
- Assert rst_ni during a DATA phase stretched by wait states:
  - All outputs at reset values while reset is low, no rsp_valid_o.
  - After release, a normal read completes correctly.
